// File: rtl/axi_frame_dispatch_pkg.sv
// rtl/axi_frame_dispatch_pkg.sv - shared types and constants for the frame dispatcher
package axi_frame_dispatch_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DROP   = 2'd2
   } state_t;

   localparam logic MODE_TDEST = 1'b0;
   localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/axi_frame_dispatch_pg_fifo.sv
// rtl/axi_frame_dispatch_pg_fifo.sv - per-channel pixel-group FIFO with registered output
// Capacity counts the output register, so DEPTH beats are held in total.
module pg_fifo #(
   parameter int WIDTH = 257,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   input  logic             pop
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t wr_ptr, rd_ptr;
   cnt_t count;
   logic do_push, load;

   // Full is judged on registered occupancy only: a same-cycle pop never frees a slot early.
   assign full    = (count + cnt_t'(rvalid)) >= cnt_t'(DEPTH);
   assign do_push = push && !full;
   assign load    = (count != '0) && (!rvalid || pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
         if (load) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
            rdata  <= mem[rd_ptr];
            rvalid <= 1'b1;
         end else if (pop) begin
            rvalid <= 1'b0;
         end
         count <= count + cnt_t'(do_push) - cnt_t'(load);
      end
   end
endmodule

// File: rtl/axi_frame_dispatch.sv
// rtl/axi_frame_dispatch.sv - routes whole AXI-Stream frames to per-channel FIFOs
// Frame length is policed against FRAME_PGNUM; short and long frames are closed with an error pulse.
module axi_frame_dispatch
   import axi_frame_dispatch_pkg::*;
#(
   parameter int IP_AMT       = 2,
   parameter int DATA_W       = 256,
   parameter int AXIS_TID_W   = 2,
   parameter int AXIS_TDEST_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int FRAME_PGNUM  = 9600,
   parameter int PGCNT_W      = $clog2(FRAME_PGNUM)
) (
   input  logic                     s_aclk,
   input  logic                     s_aresetn,
   input  logic                     mode_i,
   input  logic [AXIS_TID_W-1:0]    s_tid_i,
   input  logic [AXIS_TDEST_W-1:0]  s_tdest_i,
   input  logic [DATA_W-1:0]        s_tdata_i,
   input  logic [DATA_W/8-1:0]      s_tkeep_i,
   input  logic                     s_tlast_i,
   input  logic                     s_tvalid_i,
   output logic                     s_tready_o,
   output logic [IP_AMT*DATA_W-1:0] pg_data_o,
   output logic [IP_AMT-1:0]        pg_last_o,
   output logic [IP_AMT-1:0]        pg_valid_o,
   input  logic [IP_AMT-1:0]        pg_ready_i,
   output logic [IP_AMT-1:0]        frame_done_o,
   output logic [IP_AMT-1:0]        frame_err_o,
   output logic                     drop_o
);
   typedef logic [AXIS_TDEST_W-1:0] dest_t;
   typedef logic [AXIS_TDEST_W:0]   dest_ext_t;
   typedef logic [PGCNT_W-1:0]      pgcnt_t;

   localparam pgcnt_t LAST_IDX = pgcnt_t'(FRAME_PGNUM - 1);

   state_t  state, state_nxt;
   dest_t   dest_q, rr_ptr, cand_dest;
   pgcnt_t  pg_cnt, beat_idx;
   logic    illegal, sel_full, accept, legal_acc, at_limit, frame_end;
   logic [IP_AMT-1:0] full, push;
   logic [DATA_W:0]   push_word;
   logic    unused_inputs;

   assign unused_inputs = ^{s_tid_i, s_tkeep_i};

   // Frame start picks a fresh destination and restarts the beat index.
   always_comb begin
      cand_dest = dest_q;
      illegal   = 1'b0;
      beat_idx  = pg_cnt;
      if (state == IDLE) begin
         cand_dest = (mode_i == MODE_RR) ? rr_ptr : s_tdest_i;
         illegal   = (mode_i == MODE_TDEST) && ({1'b0, s_tdest_i} >= dest_ext_t'(IP_AMT));
         beat_idx  = '0;
      end
   end

   always_comb begin
      sel_full = 1'b0;
      for (int k = 0; k < IP_AMT; k++) begin
         if (cand_dest == dest_t'(k)) sel_full = full[k];
      end
   end

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         unique case (state)
            IDLE, ACTIVE: begin
               if (s_tlast_i)                state_nxt = IDLE;
               else if (illegal || at_limit) state_nxt = DROP;
               else                          state_nxt = ACTIVE;
            end
            DROP:    if (s_tlast_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      s_tready_o = 1'b0;
      unique case (state)
         IDLE:    s_tready_o = illegal || !sel_full;
         ACTIVE:  s_tready_o = !sel_full;
         DROP:    s_tready_o = 1'b1;
         default: s_tready_o = 1'b0;
      endcase
      s_tready_o = s_tready_o && s_aresetn;
   end

   assign accept    = s_tvalid_i && s_tready_o;
   assign legal_acc = accept && (state != DROP) && !illegal;
   assign at_limit  = (beat_idx == LAST_IDX);
   assign frame_end = legal_acc && (s_tlast_i || at_limit);
   assign push_word = {s_tlast_i || at_limit, s_tdata_i};

   always_comb begin
      push = '0;
      for (int k = 0; k < IP_AMT; k++) begin
         push[k] = legal_acc && (cand_dest == dest_t'(k));
      end
   end

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         dest_q       <= '0;
         rr_ptr       <= '0;
         pg_cnt       <= '0;
         frame_done_o <= '0;
         frame_err_o  <= '0;
         drop_o       <= 1'b0;
      end else begin
         frame_done_o <= '0;
         frame_err_o  <= '0;
         drop_o       <= accept && illegal;
         if (legal_acc) begin
            dest_q <= cand_dest;
            pg_cnt <= frame_end ? '0 : beat_idx + pgcnt_t'(1);
         end
         // Every frame handed to a channel advances the pointer, including truncated ones.
         if (frame_end) begin
            rr_ptr <= (rr_ptr == dest_t'(IP_AMT - 1)) ? '0 : rr_ptr + dest_t'(1);
            if (s_tlast_i && at_limit) frame_done_o <= push;
            else                       frame_err_o  <= push;
         end
      end
   end

   for (genvar k = 0; k < IP_AMT; k++) begin : g_ch
      logic [DATA_W:0] rd_word;
      pg_fifo #(
         .WIDTH (DATA_W + 1),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk    (s_aclk),
         .rst_n  (s_aresetn),
         .push   (push[k]),
         .wdata  (push_word),
         .full   (full[k]),
         .rdata  (rd_word),
         .rvalid (pg_valid_o[k]),
         .pop    (pg_ready_i[k] && pg_valid_o[k])
      );
      assign pg_data_o[(k+1)*DATA_W-1 -: DATA_W] = rd_word[DATA_W-1:0];
      assign pg_last_o[k] = rd_word[DATA_W];
   end
endmodule

// File: tb/tb_axi_frame_dispatch.sv
// tb/tb_axi_frame_dispatch.sv - self-checking bench for axi_frame_dispatch
// Frame-level queue model plus directed and randomized frames.
module tb_axi_frame_dispatch;
   localparam int IP_AMT  = 2;
   localparam int DATA_W  = 256;
   localparam int TID_W   = 2;
   localparam int TDEST_W = 2;
   localparam int DEPTH   = 4;
   localparam int NPG     = 8;

   logic                     s_aclk, s_aresetn, mode_i;
   logic [TID_W-1:0]         s_tid_i;
   logic [TDEST_W-1:0]       s_tdest_i;
   logic [DATA_W-1:0]        s_tdata_i;
   logic [DATA_W/8-1:0]      s_tkeep_i;
   logic                     s_tlast_i, s_tvalid_i, s_tready_o;
   logic [IP_AMT*DATA_W-1:0] pg_data_o;
   logic [IP_AMT-1:0]        pg_last_o, pg_valid_o, pg_ready_i;
   logic [IP_AMT-1:0]        frame_done_o, frame_err_o;
   logic                     drop_o;

   axi_frame_dispatch #(
      .IP_AMT(IP_AMT), .DATA_W(DATA_W), .AXIS_TID_W(TID_W), .AXIS_TDEST_W(TDEST_W),
      .FIFO_DEPTH(DEPTH), .FRAME_PGNUM(NPG)
   ) dut (
      .s_aclk(s_aclk), .s_aresetn(s_aresetn), .mode_i(mode_i), .s_tid_i(s_tid_i),
      .s_tdest_i(s_tdest_i), .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i),
      .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
      .pg_data_o(pg_data_o), .pg_last_o(pg_last_o), .pg_valid_o(pg_valid_o),
      .pg_ready_i(pg_ready_i), .frame_done_o(frame_done_o), .frame_err_o(frame_err_o),
      .drop_o(drop_o)
   );

   initial s_aclk = 1'b0;
   always #5 s_aclk = ~s_aclk;

   typedef struct packed { logic last; logic [DATA_W-1:0] data; } beat_t;

   beat_t expq [IP_AMT][$];
   bit    m_in_frame, m_dropping;
   int    m_dest, m_cnt, m_rr;
   logic [IP_AMT-1:0] exp_done, exp_err;
   logic  exp_drop;
   int    n_assert, n_fail;
   int    rx_beats[IP_AMT], rx_last[IP_AMT], done_cnt[IP_AMT], err_cnt[IP_AMT];
   int    b_beats[IP_AMT], b_last[IP_AMT], b_done[IP_AMT], b_err[IP_AMT];
   int    drop_cnt, acc_cnt, b_drop, b_acc;
   bit    rand_ready, drv_busy;

   task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit tdest_bad();
      return (mode_i == 1'b0) && (int'(s_tdest_i) >= IP_AMT);
   endfunction

   function automatic bit model_ready();
      int d;
      if (m_dropping) return 1'b1;
      if (!m_in_frame) begin
         if (tdest_bad()) return 1'b1;
         d = mode_i ? m_rr : int'(s_tdest_i);
      end else begin
         d = m_dest;
      end
      return expq[d].size() < DEPTH;
   endfunction

   task automatic model_accept();
      bit last;
      if (m_dropping) begin
         if (s_tlast_i) m_dropping = 1'b0;
         return;
      end
      if (!m_in_frame) begin
         if (tdest_bad()) begin
            exp_drop   = 1'b1;
            m_dropping = !s_tlast_i;
            return;
         end
         m_dest = mode_i ? m_rr : int'(s_tdest_i);
         m_cnt  = 0;
      end
      last = s_tlast_i || (m_cnt == NPG - 1);
      expq[m_dest].push_back({last, s_tdata_i});
      if (last) begin
         if (s_tlast_i && m_cnt == NPG - 1) exp_done[m_dest] = 1'b1;
         else                               exp_err[m_dest]  = 1'b1;
         m_rr       = (m_rr + 1) % IP_AMT;
         m_in_frame = 1'b0;
         m_dropping = !s_tlast_i;
      end else begin
         m_cnt++;
         m_in_frame = 1'b1;
      end
   endtask

   always @(negedge s_aclk) begin
      if (!s_aresetn) begin
         check("rst_tready", s_tready_o, 0);
         check("rst_valid", pg_valid_o, 0);
         check("rst_last", pg_last_o, 0);
         check("rst_data", |pg_data_o, 0);
         check("rst_pulses", {frame_done_o, frame_err_o, drop_o}, 0);
         for (int c = 0; c < IP_AMT; c++) expq[c].delete();
         m_in_frame = 0; m_dropping = 0; m_rr = 0; m_cnt = 0; m_dest = 0;
         exp_done = '0; exp_err = '0; exp_drop = 1'b0;
      end else begin
         check("frame_done", frame_done_o, exp_done);
         check("frame_err", frame_err_o, exp_err);
         check("drop", drop_o, exp_drop);
         for (int c = 0; c < IP_AMT; c++) begin
            done_cnt[c] += int'(frame_done_o[c]);
            err_cnt[c]  += int'(frame_err_o[c]);
         end
         drop_cnt += int'(drop_o);
         check("s_tready", s_tready_o, model_ready());
         for (int c = 0; c < IP_AMT; c++) begin
            if (pg_valid_o[c]) begin
               check("valid_expected", expq[c].size() != 0, 1);
               if (expq[c].size() != 0) begin
                  check("pg_beat", {pg_last_o[c], pg_data_o[c*DATA_W +: DATA_W]}, expq[c][0]);
                  if (pg_ready_i[c]) begin
                     rx_beats[c]++;
                     rx_last[c] += int'(pg_last_o[c]);
                     void'(expq[c].pop_front());
                  end
               end
            end
         end
         exp_done = '0; exp_err = '0; exp_drop = 1'b0;
         if (s_tvalid_i && s_tready_o) begin
            acc_cnt++;
            model_accept();
         end
      end
   end

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] v;
      for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge s_aclk);
         #1;
      end
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge s_aclk);
         ok = s_tready_o && s_aresetn;
         @(posedge s_aclk);
         #1;
         if (rand_ready) pg_ready_i = IP_AMT'($urandom);
      end
      if (!ok) begin
         n_assert++;
         n_fail++;
         $display("FAIL accept_timeout: beat not accepted within 300 cycles");
      end
   endtask

   task automatic send_frame(input int n, input int dest, input int abort_after, input bit rnd);
      for (int b = 0; b < n; b++) begin
         if (abort_after > 0 && b == abort_after) break;
         if (rnd && $urandom_range(3) == 0) begin
            s_tvalid_i = 1'b0;
            cyc(1);
         end
         s_tvalid_i = 1'b1;
         s_tdata_i  = rnd_data();
         s_tlast_i  = (b == n - 1);
         s_tdest_i  = (b == 0 || !rnd) ? TDEST_W'(dest) : TDEST_W'($urandom_range(3));
         if (rnd) mode_i = 1'($urandom_range(1));
         wait_accept();
      end
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      rand_ready = 1'b0;
      pg_ready_i = '1;
      while ((expq[0].size() != 0 || expq[1].size() != 0) && c < 200) begin
         cyc(1);
         c++;
      end
      cyc(2);
      check("drain_in_time", c < 200, 1);
   endtask

   task automatic apply_reset();
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
      s_aresetn  = 1'b0;
      #1;
      check("rst_immediate", {s_tready_o, pg_valid_o, pg_last_o, frame_done_o, frame_err_o, drop_o}, 0);
      cyc(3);
      s_aresetn = 1'b1;
      cyc(1);
   endtask

   task automatic snap();
      b_beats = rx_beats; b_last = rx_last; b_done = done_cnt; b_err = err_cnt;
      b_drop = drop_cnt; b_acc = acc_cnt;
   endtask

   initial begin
      s_aresetn = 1'b0; mode_i = 1'b0; s_tid_i = '0; s_tdest_i = '0; s_tdata_i = '0;
      s_tkeep_i = '1; s_tlast_i = 1'b0; s_tvalid_i = 1'b0; pg_ready_i = '1;
      rand_ready = 1'b0; drv_busy = 1'b0;
      #2;
      apply_reset();

      snap();
      send_frame(8, 1, 0, 0);
      drain();
      check("t1_ch1_beats", rx_beats[1] - b_beats[1], 8);
      check("t1_ch1_last", rx_last[1] - b_last[1], 1);
      check("t1_ch1_done", done_cnt[1] - b_done[1], 1);
      check("t1_ch0_beats", rx_beats[0] - b_beats[0], 0);

      apply_reset();
      mode_i = 1'b1;
      snap();
      repeat (3) send_frame(8, 0, 0, 0);
      drain();
      check("t2_ch0_frames", rx_last[0] - b_last[0], 2);
      check("t2_ch1_frames", rx_last[1] - b_last[1], 1);
      check("t2_ch0_done", done_cnt[0] - b_done[0], 2);
      check("t2_rr_ptr", m_rr, 1);

      mode_i = 1'b0;
      snap();
      send_frame(5, 3, 0, 0);
      drain();
      check("t3_drop", drop_cnt - b_drop, 1);
      check("t3_no_beats", (rx_beats[0] - b_beats[0]) + (rx_beats[1] - b_beats[1]), 0);

      snap();
      send_frame(5, 0, 0, 0);
      drain();
      check("t4u_beats", rx_beats[0] - b_beats[0], 5);
      check("t4u_err", err_cnt[0] - b_err[0], 1);
      check("t4u_done", done_cnt[0] - b_done[0], 0);
      snap();
      send_frame(10, 1, 0, 0);
      drain();
      check("t4o_beats", rx_beats[1] - b_beats[1], 8);
      check("t4o_last", rx_last[1] - b_last[1], 1);
      check("t4o_err", err_cnt[1] - b_err[1], 1);

      pg_ready_i = 2'b10;
      snap();
      drv_busy = 1'b1;
      fork
         begin
            send_frame(8, 0, 0, 0);
            drv_busy = 1'b0;
         end
      join_none
      cyc(12);
      check("t5_accepted", acc_cnt - b_acc, 4);
      check("t5_tready_low", s_tready_o, 0);
      pg_ready_i = 2'b11;
      for (int c = 0; c < 100 && drv_busy; c++) cyc(1);
      check("t5_driver_done", drv_busy, 0);
      drain();
      check("t5_beats", rx_beats[0] - b_beats[0], 8);
      check("t5_done", done_cnt[0] - b_done[0], 1);

      send_frame(8, 1, 3, 0);
      apply_reset();
      snap();
      send_frame(8, 0, 0, 0);
      drain();
      check("t6_beats", rx_beats[0] - b_beats[0], 8);
      check("t6_done", done_cnt[0] - b_done[0], 1);
      check("t6_ch1_beats", rx_beats[1] - b_beats[1], 0);
      check("t6_err", (err_cnt[0] - b_err[0]) + (err_cnt[1] - b_err[1]), 0);

      rand_ready = 1'b1;
      repeat (40) begin
         send_frame(($urandom_range(3) == 0) ? int'($urandom_range(11, 1)) : NPG,
                    int'($urandom_range(3)), 0, 1);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_frame_dispatch.md
# axi_frame_dispatch

Second-generation pixel-group front end for the frame-fetch pipeline.
- Accepts 256-bit pixel groups on an AXI-Stream slave.
- Routes each whole frame to one of IP_AMT image-processor channels:
  - TDEST mode: by the tdest of the frame's first beat.
  - ROUND-ROBIN mode: by a rotating pointer.
- Buffers each channel in its own FIFO and checks frame length against FRAME_PGNUM.
- Sits between the AXI-Stream ingress and the per-channel cell controllers, replacing the single-beat controller with per-channel buffering and frame-integrity reporting.

## Interface
Parameters:
- IP_AMT, 2, number of image-processor channels (≥1)
- DATA_W, 256, pixel-group width
- AXIS_TID_W, 2, tid width
- AXIS_TDEST_W, max(1,$clog2(IP_AMT)), tdest width
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
- FRAME_PGNUM, 9600, pixel groups per frame (640x480x8b / 256b)
- PGCNT_W, $clog2(FRAME_PGNUM), beat-counter width

Ports:
- s_aclk  in  1  clock
- s_aresetn  in  1  reset. One clock; reset is asynchronous and active-low.
- mode_i  in  1  0 = TDEST routing, 1 = ROUND-ROBIN; sampled only at frame start
- s_tid_i  in  AXIS_TID_W  ignored
- s_tdest_i  in  AXIS_TDEST_W  destination channel (TDEST mode)
- s_tdata_i  in  DATA_W  pixel group
- s_tkeep_i  in  DATA_W/8  ignored (full beats only)
- s_tlast_i  in  1  last beat of frame
- s_tvalid_i  in  1  beat valid
- s_tready_o  out  1  beat accepted when valid&ready
- pg_data_o  out  IP_AMT*DATA_W  per-channel pixel group; channel k at [(k+1)*DATA_W-1 -: DATA_W]
- pg_last_o  out  IP_AMT  per-channel last-of-frame
- pg_valid_o  out  IP_AMT  per-channel valid
- pg_ready_i  in  IP_AMT  per-channel ready
- frame_done_o  out  IP_AMT  1-cycle pulse: correct-length frame fully accepted
- frame_err_o  out  IP_AMT  1-cycle pulse: length error on that channel
- drop_o  out  1  1-cycle pulse: frame discarded (illegal tdest)

## Operation
- States: IDLE, ACTIVE, DROP.
- IDLE, first beat:
  - Destination dest = mode_i ? rr_ptr : s_tdest_i.
  - TDEST mode with s_tdest_i ≥ IP_AMT → DROP. The beat is consumed and drop_o pulses.
  - Otherwise the beat is pushed to fifo[dest], dest is latched, and the state goes to ACTIVE. A single-beat frame (tlast set) stays in IDLE.
- ACTIVE: all beats go to the latched dest; tdest changes mid-frame are ignored.
- DROP: s_tready_o=1 and beats are discarded until the tlast beat, then IDLE.
- s_tready_o:
  - IDLE: !full of the candidate dest (1 if the tdest is illegal).
  - ACTIVE: !full[dest].
  - DROP: 1.
- Beat counter pg_cnt resets to 0 at each frame start and increments per accepted beat.
- Correct end: tlast with pg_cnt==FRAME_PGNUM-1 → frame_done_o[dest] pulses and the state returns to IDLE.
- Underrun: tlast with pg_cnt<FRAME_PGNUM-1 → beat is stored with last=1, frame_err_o[dest] pulses, IDLE.
- Overrun: beat at pg_cnt==FRAME_PGNUM-1 without tlast → beat is stored with last forced to 1, frame_err_o[dest] pulses, state goes to DROP.
- rr_ptr advances (wrapping IP_AMT-1→0) on every frame end delivered to a channel (correct, underrun or overrun). It does not advance on dropped frames.
- mode_i changes take effect only at the next frame start.

## Timing
- Reset values:
  - s_tready_o=0, all pg_valid_o=0, pg_last_o=0, pg_data_o=0.
  - frame_done_o=0, frame_err_o=0, drop_o=0.
  - State IDLE, rr_ptr=0, pg_cnt=0, FIFOs empty.
- Reset mid-frame discards all FIFO contents and the partial frame, with no pulses.
- Latency: a beat accepted at edge N is visible on pg_valid_o/pg_data_o after edge N+1.
- Throughput: 1 beat/cycle per frame when the destination is not stalled.
- FIFO full: accept nothing, even if a pop occurs in the same cycle (no full bypass).
- Push and pop in the same cycle when not full: both occur; occupancy is unchanged.
- frame_done_o, frame_err_o and drop_o are registered and assert in the cycle after the triggering acceptance.
- AXI rule: outputs hold stable while pg_valid_o=1 and pg_ready_i=0.

## Structure
- Package axi_frame_dispatch_pkg:
  - state enum {IDLE, ACTIVE, DROP}
  - mode constants MODE_TDEST=0, MODE_RR=1
- Sub-module pg_fifo:
  - Synchronous FIFO, width DATA_W+1 (data+last), depth FIFO_DEPTH, registered output.
  - Instantiated IP_AMT times in a generate loop.

## Test plan
- Reset, then TDEST mode, FRAME_PGNUM=8, 8 beats tdest=1, pg_ready_i=11 → channel 1 receives 8 beats with last on beat 8; frame_done_o[1] pulses once; channel 0 stays idle.
- ROUND-ROBIN mode, IP_AMT=2, three 8-beat frames → frames land on channels 0,1,0; rr_ptr=1 at end.
- tdest=3 with IP_AMT=2, 5-beat frame → s_tready_o=1 throughout, drop_o pulses once, no pg_valid_o.
- Underrun (tlast on beat 5 of 8) → 5 beats out, last on the 5th; frame_err_o pulses. Overrun (10 beats, tlast on 10th) → 8 beats out, last forced on the 8th, beats 9–10 discarded, frame_err_o pulses.
- pg_ready_i[0]=0 with FIFO_DEPTH=4 → exactly 4 beats accepted, then s_tready_o=0. Releasing ready resumes without loss or duplication.
- s_aresetn asserted at beat 3 of a frame → all outputs 0 at once; after release, a clean 8-beat frame completes normally.
